// File: rtl/hilo_writeback_pkg.sv
// Shared definitions for the HI/LO writeback stage: FSM state encoding
// and the mult/div operation encoding used by the control unit.
package hilo_writeback_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_TIMEOUT = 2'd2
   } state_t;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   // True when a completion must be turned into a divide-by-zero exception
   // rather than a register write.
   function automatic logic is_div0_completion(input logic op, input logic div0);
      return (op == OP_DIV) && div0;
   endfunction

endpackage

// File: rtl/hilo_writeback.sv
// HI/LO writeback stage: owns the architectural HI/LO pair, tracks one
// in-flight mult/div, commits or raises div-by-zero on completion, serves
// mthi/mtlo/mfhi/mflo and stalls requests while a result is outstanding.
module hilo_writeback
   import hilo_writeback_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MAX_LAT = 34
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic             op_i,
   input  logic             md_done_i,
   input  logic [WIDTH-1:0] md_hi_i,
   input  logic [WIDTH-1:0] md_lo_i,
   input  logic             md_div0_i,
   input  logic             mthi_i,
   input  logic             mtlo_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             mfhi_i,
   input  logic             mflo_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             rvalid_o,
   output logic             stall_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             div0_exc_o,
   output logic             timeout_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = $clog2(MAX_LAT + 1);
   localparam logic [CW-1:0] CNT_LIMIT = CW'(MAX_LAT - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

   state_t           state_r;
   logic             op_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;
   logic [WIDTH-1:0] rdata_r;
   logic             rvalid_r;
   logic             done_r;
   logic             div0_r;
   logic             timeout_r;
   logic             idle_s;
   logic             req_s;
   logic             stall_s;

   // Request decode and stall: anything asked for outside IDLE is held off.
   always_comb begin
      idle_s  = (state_r == ST_IDLE);
      req_s   = start_i | mthi_i | mtlo_i | mfhi_i | mflo_i;
      stall_s = 1'b0;
      if (!idle_s) begin
         stall_s = req_s;
      end else begin
         stall_s = 1'b0;
      end
   end

   // FSM with HI/LO write mux, latency watchdog and completion pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         op_r      <= OP_MULT;
         cnt_r     <= CNT_ZERO;
         hi_r      <= '0;
         lo_r      <= '0;
         done_r    <= 1'b0;
         div0_r    <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         div0_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               // Register writes land even when a launch is accepted in the
               // same cycle; the later commit simply overwrites them.
               if (mthi_i) hi_r <= wdata_i;
               if (mtlo_i) lo_r <= wdata_i;
               if (start_i) begin
                  state_r <= ST_PENDING;
                  op_r    <= op_i;
                  cnt_r   <= CNT_ZERO;
               end
            end
            ST_PENDING: begin
               if (cnt_r != CNT_LIMIT) cnt_r <= cnt_r + CNT_ONE;
               // A completion on the last allowed cycle still beats the watchdog.
               if (md_done_i) begin
                  state_r <= ST_IDLE;
                  if (is_div0_completion(op_r, md_div0_i)) begin
                     div0_r <= 1'b1;
                  end else begin
                     hi_r   <= md_hi_i;
                     lo_r   <= md_lo_i;
                     done_r <= 1'b1;
                  end
               end else if (cnt_r == CNT_LIMIT) begin
                  state_r   <= ST_TIMEOUT;
                  timeout_r <= 1'b1;
               end
            end
            ST_TIMEOUT: begin
               state_r <= ST_TIMEOUT;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Read port: unstalled mfhi/mflo returns the pre-write value next cycle; HI wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_r  <= '0;
         rvalid_r <= 1'b0;
      end else if (idle_s && (mfhi_i || mflo_i)) begin
         rdata_r  <= mfhi_i ? hi_r : lo_r;
         rvalid_r <= 1'b1;
      end else begin
         rvalid_r <= 1'b0;
      end
   end

   assign rdata_o    = rdata_r;
   assign rvalid_o   = rvalid_r;
   assign stall_o    = stall_s;
   assign busy_o     = (state_r == ST_PENDING);
   assign done_o     = done_r;
   assign div0_exc_o = div0_r;
   assign timeout_o  = timeout_r;
   assign hi_o       = hi_r;
   assign lo_o       = lo_r;

endmodule

// File: tb/tb_hilo_writeback.sv
// Self-checking bench for hilo_writeback: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_hilo_writeback;

   localparam int WIDTH   = 32;
   localparam int MAX_LAT = 34;

   logic             clk = 1'b0;
   logic             reset;
   logic             start_i, op_i, md_done_i, md_div0_i;
   logic [WIDTH-1:0] md_hi_i, md_lo_i, wdata_i;
   logic             mthi_i, mtlo_i, mfhi_i, mflo_i;
   logic [WIDTH-1:0] rdata_o, hi_o, lo_o;
   logic             rvalid_o, stall_o, busy_o, done_o, div0_exc_o, timeout_o;

   hilo_writeback #(.WIDTH(WIDTH), .MAX_LAT(MAX_LAT)) dut (
      .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
      .md_done_i(md_done_i), .md_hi_i(md_hi_i), .md_lo_i(md_lo_i),
      .md_div0_i(md_div0_i), .mthi_i(mthi_i), .mtlo_i(mtlo_i),
      .wdata_i(wdata_i), .mfhi_i(mfhi_i), .mflo_i(mflo_i),
      .rdata_o(rdata_o), .rvalid_o(rvalid_o), .stall_o(stall_o),
      .busy_o(busy_o), .done_o(done_o), .div0_exc_o(div0_exc_o),
      .timeout_o(timeout_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: one outstanding operation, its age, and the register pair.
   bit               m_known = 1'b0;
   bit               m_pending, m_dead, m_isdiv;
   int               m_age;
   logic [WIDTH-1:0] m_hi, m_lo, m_rdata;
   bit               m_rvalid, m_done, m_div0;

   task automatic check_eq(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic clr();
      reset = 1'b0; start_i = 1'b0; op_i = 1'b0; md_done_i = 1'b0; md_div0_i = 1'b0;
      md_hi_i = '0; md_lo_i = '0; wdata_i = '0;
      mthi_i = 1'b0; mtlo_i = 1'b0; mfhi_i = 1'b0; mflo_i = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_step();
      m_done = 1'b0; m_div0 = 1'b0; m_rvalid = 1'b0;
      if (reset) begin
         m_known = 1'b1; m_pending = 1'b0; m_dead = 1'b0; m_isdiv = 1'b0; m_age = 0;
         m_hi = '0; m_lo = '0; m_rdata = '0;
      end else if (!m_pending && !m_dead) begin
         if (mfhi_i || mflo_i) begin
            m_rdata  = mfhi_i ? m_hi : m_lo;
            m_rvalid = 1'b1;
         end
         if (mthi_i) m_hi = wdata_i;
         if (mtlo_i) m_lo = wdata_i;
         if (start_i) begin
            m_pending = 1'b1; m_isdiv = op_i; m_age = 0;
         end
      end else if (m_pending) begin
         if (md_done_i) begin
            m_pending = 1'b0;
            if (m_isdiv && md_div0_i) m_div0 = 1'b1;
            else begin
               m_hi = md_hi_i; m_lo = md_lo_i; m_done = 1'b1;
            end
         end else if (m_age >= MAX_LAT - 1) begin
            m_pending = 1'b0; m_dead = 1'b1;
         end else begin
            m_age++;
         end
      end
   endtask

   // One cycle: check combinational outputs, clock, then check registered outputs.
   task automatic tick();
      bit any_req;
      #1;
      any_req = start_i | mthi_i | mtlo_i | mfhi_i | mflo_i;
      if (m_known && !reset) begin
         check_eq("stall", {31'd0, stall_o}, {31'd0, (m_pending || m_dead) && any_req});
         check_eq("busy",  {31'd0, busy_o},  {31'd0, m_pending});
      end
      @(posedge clk);
      model_step();
      #1;
      check_eq("rdata",   rdata_o, m_rdata);
      check_eq("rvalid",  {31'd0, rvalid_o},   {31'd0, m_rvalid});
      check_eq("done",    {31'd0, done_o},     {31'd0, m_done});
      check_eq("div0",    {31'd0, div0_exc_o}, {31'd0, m_div0});
      check_eq("timeout", {31'd0, timeout_o},  {31'd0, m_dead});
      check_eq("hi",      hi_o, m_hi);
      check_eq("lo",      lo_o, m_lo);
   endtask

   task automatic do_reset();
      clr(); reset = 1'b1; tick(); clr();
   endtask

   initial begin
      clr();
      // 1: reset, then mthi/mtlo and read back
      do_reset();
      check_eq("rst_hi", hi_o, 32'h0000_0000);
      mthi_i = 1'b1; wdata_i = 32'h1234_5678; tick(); clr();
      mtlo_i = 1'b1; wdata_i = 32'h9ABC_DEF0; tick(); clr();
      mfhi_i = 1'b1; tick(); clr();
      check_eq("t1_mfhi", rdata_o, 32'h1234_5678);
      mflo_i = 1'b1; tick(); clr();
      check_eq("t1_mflo", rdata_o, 32'h9ABC_DEF0);

      // 2: mult with mfhi held throughout
      start_i = 1'b1; op_i = 1'b0; tick(); clr();
      mfhi_i = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      md_done_i = 1'b1; md_hi_i = 32'hFFFF_FFFF; md_lo_i = 32'hFFFF_FFFE; tick();
      md_done_i = 1'b0;
      check_eq("t2_done", {31'd0, done_o}, 32'd1);
      tick(); clr();
      check_eq("t2_rdata", rdata_o, 32'hFFFF_FFFF);

      // 3: div by zero leaves HI/LO alone
      start_i = 1'b1; op_i = 1'b1; tick(); clr();
      tick();
      md_done_i = 1'b1; md_div0_i = 1'b1; md_hi_i = 32'h1111_1111; md_lo_i = 32'h2222_2222; tick(); clr();
      check_eq("t3_div0", {31'd0, div0_exc_o}, 32'd1);
      tick();
      check_eq("t3_hi", hi_o, 32'hFFFF_FFFF);

      // 4: watchdog, sticky timeout, then reset and a spurious done
      start_i = 1'b1; op_i = 1'b0; tick(); clr();
      for (int i = 0; i < MAX_LAT; i++) tick();
      check_eq("t4_timeout", {31'd0, timeout_o}, 32'd1);
      mflo_i = 1'b1; tick(); tick(); clr();
      do_reset();
      md_done_i = 1'b1; md_hi_i = 32'h0000_BEEF; md_lo_i = 32'h0000_CAFE; tick(); clr();
      check_eq("t4_spurious", hi_o, 32'h0000_0000);

      // done on the very last allowed cycle beats the watchdog
      start_i = 1'b1; tick(); clr();
      for (int i = 0; i < MAX_LAT - 1; i++) tick();
      md_done_i = 1'b1; md_hi_i = 32'h0000_0777; md_lo_i = 32'h0000_0888; tick(); clr();
      check_eq("edge_done", {31'd0, done_o}, 32'd1);

      // 5: spurious done in IDLE; same-cycle write and read
      md_done_i = 1'b1; md_hi_i = 32'h0000_DEAD; tick(); clr();
      mthi_i = 1'b1; mfhi_i = 1'b1; wdata_i = 32'h0000_0005; tick(); clr();
      check_eq("t5_old", rdata_o, 32'h0000_0777);
      mfhi_i = 1'b1; tick(); clr();
      check_eq("t5_new", rdata_o, 32'h0000_0005);

      // 6: relaunch attempt while pending; dual write
      start_i = 1'b1; tick(); tick(); tick(); clr();
      md_done_i = 1'b1; md_hi_i = 32'h0000_0001; md_lo_i = 32'h0000_0002; tick(); clr();
      check_eq("t6_idle", {31'd0, busy_o}, 32'd0);
      mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = 32'hA5A5_A5A5; tick(); clr();
      check_eq("t6_lo", lo_o, 32'hA5A5_A5A5);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ((m_dead && ($urandom % 4 == 0)) || ($urandom % 400 == 0)) begin
            do_reset();
         end else begin
            start_i   = ($urandom % 6 == 0);
            op_i      = $urandom % 2;
            md_done_i = m_pending ? ($urandom % 12 == 0) : ($urandom % 40 == 0);
            md_div0_i = ($urandom % 3 == 0);
            md_hi_i   = $urandom;
            md_lo_i   = $urandom;
            mthi_i    = ($urandom % 5 == 0);
            mtlo_i    = ($urandom % 5 == 0);
            wdata_i   = $urandom;
            mfhi_i    = ($urandom % 4 == 0);
            mflo_i    = ($urandom % 4 == 0);
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
